fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register and the F/D pipeline register, and drives the D stage with `IRD`, `PC4D`, `ExcCodeF` and `bdD`. It consumes the D stage's next-PC controls (`NPC_Sel`, `NPC`, `Branch`, `MF_RS_D_OUT`, `iseretD`), the hazard unit's stall, and the CP0 exception/EPC signals. It also detects fetch address errors (AdEL) and tags delay-slot instructions.

---
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. Owns the PC
//   register and the F/D pipeline register. It selects the next PC from the
//   D-stage controls, flags fetch address errors (AdEL) and tags instructions
//   that sit in a branch delay slot.
//
// Ports
//   Clk          in   1   rising-edge clock
//   Reset        in   1   synchronous, active-high reset
//   StallD       in   1   hold PC and F/D register
//   NPC_Sel      in   2   0 = PC+4, 1 = cond. branch, 2 = j/jal, 3 = jr/jalr
//   Branch       in   1   branch compare result (NPC_Sel == 1 only)
//   NPC          in  32   D-stage branch/jump target
//   MF_RS_D_OUT  in  32   forwarded rs value, jr/jalr target
//   iseretD      in   1   eret decoded in D
//   EPC          in  32   CP0 EPC
//   exp_in       in   1   CP0 exception/interrupt taken this cycle
//   PCF          out 32   fetch address (direct PC register output)
//   IRF          in  32   instruction memory data for PCF
//   IRD          out 32   F/D: instruction
//   PC4D         out 32   F/D: fetched PC + 4
//   ExcCodeF     out  5   F/D: fetch exception code
//   bdD          out  1   F/D: instruction is in a branch delay slot
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] PC_RESET         = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT         = 32'h0000_4FFC,
  parameter logic [31:0] EXC_ENTRY        = 32'h0000_4180,
  // "No exception" code, matching ExcCode_default of the exception package.
  parameter logic [4:0]  EXC_CODE_DEFAULT = 5'd0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallD,
  input  logic [1:0]  NPC_Sel,
  input  logic        Branch,
  input  logic [31:0] NPC,
  input  logic [31:0] MF_RS_D_OUT,
  input  logic        iseretD,
  input  logic [31:0] EPC,
  input  logic        exp_in,
  output logic [31:0] PCF,
  input  logic [31:0] IRF,
  output logic [31:0] IRD,
  output logic [31:0] PC4D,
  output logic [6:2]  ExcCodeF,
  output logic        bdD
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc_r;
  logic [31:0] ird_r;
  logic [31:0] pc4d_r;
  logic [4:0]  exc_r;
  logic        bd_r;

  logic [31:0] pc4_s;
  logic        adel_s;
  logic [31:0] inst_s;
  logic [4:0]  exc_s;
  logic        bd_s;
  logic [31:0] tgt_s;

  // Fetch-side values: PC+4, address-error detection, nop substitution.
  always_comb begin
    pc4_s  = pc_r + 32'd4;
    adel_s = (pc_r[1:0] != 2'b00) || (pc_r < PC_RESET) || (pc_r > PC_LIMIT);
    if (adel_s) begin
      inst_s = 32'h0000_0000;
      exc_s  = EXC_ADEL;
    end else begin
      inst_s = IRF;
      exc_s  = EXC_CODE_DEFAULT;
    end
    // Anything other than sequential flow in D means F holds its delay slot.
    bd_s = (NPC_Sel != 2'd0);
  end

  // Next-PC target selection from the D-stage controls.
  always_comb begin
    tgt_s = pc4_s;
    case (NPC_Sel)
      2'd0:    tgt_s = pc4_s;
      2'd1:    tgt_s = Branch ? NPC : pc4_s;
      2'd2:    tgt_s = NPC;
      2'd3:    tgt_s = MF_RS_D_OUT;
      default: tgt_s = pc4_s;
    endcase
  end

  // PC and F/D register update: reset > exception > stall > eret > normal.
  // Exceptions override a stall so the handler is entered immediately.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_r   <= PC_RESET;
      ird_r  <= 32'h0000_0000;
      pc4d_r <= 32'h0000_0000;
      exc_r  <= EXC_CODE_DEFAULT;
      bd_r   <= 1'b0;
    end else if (exp_in) begin
      pc_r   <= EXC_ENTRY;
      ird_r  <= 32'h0000_0000;
      pc4d_r <= 32'h0000_0000;
      exc_r  <= EXC_CODE_DEFAULT;
      bd_r   <= 1'b0;
    end else if (StallD) begin
      pc_r   <= pc_r;
      ird_r  <= ird_r;
      pc4d_r <= pc4d_r;
      exc_r  <= exc_r;
      bd_r   <= bd_r;
    end else if (iseretD) begin
      // eret has no delay slot: the instruction fetched behind it is killed.
      pc_r   <= EPC;
      ird_r  <= 32'h0000_0000;
      pc4d_r <= 32'h0000_0000;
      exc_r  <= EXC_CODE_DEFAULT;
      bd_r   <= 1'b0;
    end else begin
      // A bad jr target is loaded as-is; AdEL is raised on its fetch.
      pc_r   <= tgt_s;
      ird_r  <= inst_s;
      pc4d_r <= pc4_s;
      exc_r  <= exc_s;
      bd_r   <= bd_s;
    end
  end

  assign PCF      = pc_r;
  assign IRD      = ird_r;
  assign PC4D     = pc4d_r;
  assign ExcCodeF = exc_r;
  assign bdD      = bd_r;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [4:0] XD = 5'd0;   // default exception code
  localparam logic [4:0] XA = 5'd4;   // AdEL

  logic        Clk;
  logic        Reset;
  logic        StallD;
  logic [1:0]  NPC_Sel;
  logic        Branch;
  logic [31:0] NPC;
  logic [31:0] MF_RS_D_OUT;
  logic        iseretD;
  logic [31:0] EPC;
  logic        exp_in;
  logic [31:0] PCF;
  logic [31:0] IRF;
  logic [31:0] IRD;
  logic [31:0] PC4D;
  logic [6:2]  ExcCodeF;
  logic        bdD;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .StallD(StallD), .NPC_Sel(NPC_Sel),
    .Branch(Branch), .NPC(NPC), .MF_RS_D_OUT(MF_RS_D_OUT),
    .iseretD(iseretD), .EPC(EPC), .exp_in(exp_in), .PCF(PCF), .IRF(IRF),
    .IRD(IRD), .PC4D(PC4D), .ExcCodeF(ExcCodeF), .bdD(bdD)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] npc;
    logic [31:0] rs;
    logic        eret;
    logic [31:0] epc;
    logic        exc;
    logic [31:0] irf;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic [31:0] e_pc4;
    logic [4:0]  e_exc;
    logic        e_bd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stall, logic [1:0] sel,
                              logic br, logic [31:0] npc, logic [31:0] rs,
                              logic eret, logic [31:0] epc, logic exc,
                              logic [31:0] irf, logic [31:0] e_pc,
                              logic [31:0] e_ir, logic [31:0] e_pc4,
                              logic [4:0] e_exc, logic e_bd);
    vec_t v;
    v.rst = rst; v.stall = stall; v.sel = sel; v.br = br; v.npc = npc;
    v.rs = rs; v.eret = eret; v.epc = epc; v.exc = exc; v.irf = irf;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_pc4 = e_pc4; v.e_exc = e_exc;
    v.e_bd = e_bd;
    return v;
  endfunction

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Apply one vector at the falling edge, clock it, check after the edge.
  task automatic step(string tag, vec_t v);
    @(negedge Clk);
    Reset = v.rst; StallD = v.stall; NPC_Sel = v.sel; Branch = v.br;
    NPC = v.npc; MF_RS_D_OUT = v.rs; iseretD = v.eret; EPC = v.epc;
    exp_in = v.exc; IRF = v.irf;
    @(posedge Clk);
    #1;
    chk32({tag, ".PCF"},  PCF,  v.e_pc);
    chk32({tag, ".IRD"},  IRD,  v.e_ir);
    chk32({tag, ".PC4D"}, PC4D, v.e_pc4);
    chk32({tag, ".Exc"},  {27'd0, ExcCodeF}, {27'd0, v.e_exc});
    chk32({tag, ".bdD"},  {31'd0, bdD}, {31'd0, v.e_bd});
  endtask

  localparam logic [31:0] I  = 32'h2408_0001;
  localparam logic [31:0] BI = 32'h1000_0006;
  localparam logic [31:0] DS = 32'h2409_0002;

  initial begin
    Reset = 1'b1; StallD = 1'b0; NPC_Sel = 2'd0; Branch = 1'b0;
    NPC = 32'h0; MF_RS_D_OUT = 32'h0; iseretD = 1'b0; EPC = 32'h0;
    exp_in = 1'b0; IRF = 32'h0;

    //          rst stl sel br npc           rs            er epc           ex irf            pc            ir            pc4           exc bd
    vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3000,     32'h0,        32'h0,        XD,0)); // reset
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3004,     I,            32'h3004,     XD,0));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3008,     I,            32'h3008,     XD,0));
    vecs.push_back(mk(1,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3000,     32'h0,        32'h0,        XD,0)); // mid-run reset
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3004,     I,            32'h3004,     XD,0));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,BI,           32'h3008,     BI,           32'h3008,     XD,0)); // branch fetched
    vecs.push_back(mk(0,0,1,1,32'h3020,     32'h0,        0,32'h0,        0,DS,           32'h3020,     DS,           32'h300C,     XD,1)); // taken
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3024,     I,            32'h3024,     XD,0));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,BI,           32'h3028,     BI,           32'h3028,     XD,0));
    vecs.push_back(mk(0,0,1,0,32'h3100,     32'h0,        0,32'h0,        0,DS,           32'h302C,     DS,           32'h302C,     XD,1)); // not taken
    vecs.push_back(mk(0,1,3,0,32'h0,        32'h3040,     0,32'h0,        0,I,            32'h302C,     DS,           32'h302C,     XD,1)); // stall
    vecs.push_back(mk(0,1,3,0,32'h0,        32'h3040,     0,32'h0,        0,I,            32'h302C,     DS,           32'h302C,     XD,1)); // stall
    vecs.push_back(mk(0,0,3,0,32'h0,        32'h3040,     0,32'h0,        0,32'h8,        32'h3040,     32'h8,        32'h3030,     XD,1)); // jr
    vecs.push_back(mk(0,0,3,0,32'h0,        32'h3002,     0,32'h0,        0,I,            32'h3002,     I,            32'h3044,     XD,1)); // jr misaligned
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,32'hDEADBEEF, 32'h3006,     32'h0,        32'h3006,     XA,0)); // AdEL
    vecs.push_back(mk(0,0,2,0,32'h5000,     32'h0,        0,32'h0,        0,I,            32'h5000,     32'h0,        32'h300A,     XA,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h5004,     32'h0,        32'h5004,     XA,0)); // 5000 AdEL
    vecs.push_back(mk(0,0,2,0,32'h4FFC,     32'h0,        0,32'h0,        0,I,            32'h4FFC,     32'h0,        32'h5008,     XA,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h5000,     I,            32'h5000,     XD,0)); // limit legal
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h5004,     32'h0,        32'h5004,     XA,0)); // limit+4
    vecs.push_back(mk(0,0,2,0,32'h2FFC,     32'h0,        0,32'h0,        0,I,            32'h2FFC,     32'h0,        32'h5008,     XA,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3000,     32'h0,        32'h3000,     XA,0)); // below base
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h0,        0,32'h0,        1,I,            32'h4180,     32'h0,        32'h0,        XD,0)); // exc + stall
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h4184,     I,            32'h4184,     XD,0));
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,32'h3010,     0,I,            32'h3010,     32'h0,        32'h0,        XD,0)); // eret
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        0,32'h0,        0,I,            32'h3014,     I,            32'h3014,     XD,0));
    vecs.push_back(mk(0,1,0,0,32'h0,        32'h0,        1,32'h3100,     0,I,            32'h3014,     I,            32'h3014,     XD,0)); // stall beats eret
    vecs.push_back(mk(0,0,0,0,32'h0,        32'h0,        1,32'h3100,     1,I,            32'h4180,     32'h0,        32'h0,        XD,0)); // exc beats eret

    for (int k = 0; k < vecs.size(); k++) begin
      step($sformatf("v%0d", k), vecs[k]);
    end

    // Hand sequence: reset outranks a simultaneous exception.
    step("rst_vs_exc", mk(1,0,0,0,32'h0,32'h0,0,32'h0,1,I,
                          32'h3000,32'h0,32'h0,XD,0));
    // Hand sequence: jump to the top of the address space, PC+4 wraps to 0.
    step("wrap_a", mk(0,0,0,0,32'h0,32'h0,0,32'h0,0,I,
                      32'h3004,I,32'h3004,XD,0));
    step("wrap_b", mk(0,0,2,0,32'hFFFF_FFFC,32'h0,0,32'h0,0,I,
                      32'hFFFF_FFFC,I,32'h3008,XD,1));
    step("wrap_c", mk(0,0,0,0,32'h0,32'h0,0,32'h0,0,I,
                      32'h0000_0000,32'h0,32'h0000_0000,XA,0));
    step("wrap_d", mk(0,0,0,0,32'h0,32'h0,0,32'h0,0,I,
                      32'h0000_0004,32'h0,32'h0000_0004,XA,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
